// File: rtl/cga_text_fetch_if.sv
// Signal bundle between the CRTC/VRAM-arbiter side and the CGA text/graphics fetch sequencer.
// The fetcher uses the master modport; the surrounding logic (or a testbench) uses slave.
interface cga_text_fetch_if;
    logic        char_strobe;
    logic [13:0] crtc_addr;
    logic [4:0]  row_addr;
    logic        display_enable;
    logic        grph_mode;
    logic [18:0] pixel_addr;
    logic        pixel_read;
    logic [7:0]  pixel_data;
    logic [7:0]  char_byte;
    logic [7:0]  attr_byte;
    logic        cell_valid;
    logic        fetch_overrun;

    modport master (
        input  char_strobe, crtc_addr, row_addr, display_enable, grph_mode, pixel_data,
        output pixel_addr, pixel_read, char_byte, attr_byte, cell_valid, fetch_overrun
    );

    modport slave (
        output char_strobe, crtc_addr, row_addr, display_enable, grph_mode, pixel_data,
        input  pixel_addr, pixel_read, char_byte, attr_byte, cell_valid, fetch_overrun
    );
endinterface

// File: rtl/cga_text_fetch.sv
// Per-cell VRAM fetch sequencer: reads two bytes per character cell into a shadow
// buffer and presents them to the serializer at the following cell strobe.
module cga_text_fetch #(
    parameter logic [18:0] VRAM_BASE = 19'h00000
) (
    input logic               clk,
    input logic               reset,
    cga_text_fetch_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR0,
        S_ADDR1,
        S_CAP1
    } state_t;

    state_t      r_state;
    logic [13:0] r_a0;
    logic [18:0] r_pixel_addr;
    logic        r_pixel_read;
    logic [7:0]  r_shadow0;
    logic [7:0]  r_shadow1;
    logic        r_shadow_valid;
    logic [7:0]  r_char_byte;
    logic [7:0]  r_attr_byte;
    logic        r_cell_valid;
    logic        r_fetch_overrun;

    logic [13:0] w_a0;
    logic [13:0] w_a1;
    logic        w_launch;
    logic        w_unused;

    // Graphics mode interleaves even/odd scan lines into the two 8 KB halves of the window.
    assign w_a0     = bus.grph_mode ? {bus.row_addr[0], bus.crtc_addr[11:0], 1'b0}
                                    : {bus.crtc_addr[12:0], 1'b0};
    assign w_a1     = r_a0 + 14'd1;
    assign w_launch = bus.char_strobe && bus.display_enable && (r_state == S_IDLE);
    assign w_unused = ^{bus.row_addr[4:1], bus.crtc_addr[13]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_a0            <= 14'h0000;
            r_pixel_addr    <= 19'h00000;
            r_pixel_read    <= 1'b0;
            r_shadow0       <= 8'h00;
            r_shadow1       <= 8'h00;
            r_shadow_valid  <= 1'b0;
            r_char_byte     <= 8'h00;
            r_attr_byte     <= 8'h00;
            r_cell_valid    <= 1'b0;
            r_fetch_overrun <= 1'b0;
        end else begin
            if (bus.char_strobe) begin
                r_char_byte    <= r_shadow0;
                r_attr_byte    <= r_shadow1;
                r_cell_valid   <= r_shadow_valid;
                r_shadow_valid <= 1'b0;
                if (!bus.display_enable) begin
                    r_shadow0 <= 8'h00;
                    r_shadow1 <= 8'h00;
                end
                if (r_state != S_IDLE) begin
                    r_fetch_overrun <= 1'b1;
                end
            end

            // Captures of an in-flight fetch are placed last so they win over a colliding strobe.
            case (r_state)
                S_IDLE: begin
                    r_pixel_read <= 1'b0;
                    if (w_launch) begin
                        r_state      <= S_ADDR0;
                        r_a0         <= w_a0;
                        r_pixel_addr <= VRAM_BASE | {5'b0, w_a0};
                        r_pixel_read <= 1'b1;
                    end
                end
                S_ADDR0: begin
                    r_state      <= S_ADDR1;
                    r_pixel_addr <= VRAM_BASE | {5'b0, w_a1};
                    r_pixel_read <= 1'b1;
                end
                S_ADDR1: begin
                    r_state      <= S_CAP1;
                    r_shadow0    <= bus.pixel_data;
                    r_pixel_read <= 1'b0;
                end
                S_CAP1: begin
                    r_state        <= S_IDLE;
                    r_shadow1      <= bus.pixel_data;
                    r_shadow_valid <= 1'b1;
                    r_pixel_read   <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_pixel_read <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pixel_addr    = r_pixel_addr;
    assign bus.pixel_read    = r_pixel_read;
    assign bus.char_byte     = r_char_byte;
    assign bus.attr_byte     = r_attr_byte;
    assign bus.cell_valid    = r_cell_valid;
    assign bus.fetch_overrun = r_fetch_overrun;

endmodule

// File: tb/tb_cga_text_fetch.sv
// Scoreboard bench for cga_text_fetch: two instances (base 0 and base 0x18000) share one
// stimulus stream and one VRAM model; expected reads and cell outputs are queued at drive time.
module tb_cga_text_fetch;

    typedef struct {
        logic [7:0] c;
        logic [7:0] a;
        logic       v;
        logic       ov;
    } cell_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        strobe;
    logic [13:0] crtc;
    logic [4:0]  row;
    logic        de;
    logic        grph;
    logic [7:0]  pixData;
    logic [7:0]  vram [0:16383];

    int          nChecks = 0;
    int          nPass = 0;
    int          cyc = 0;
    logic        cellDue = 1'b0;
    logic [13:0] addrQ[$];
    cell_t       cellQ[$];

    logic [7:0]  mS0, mS1, mD0, mD1;
    logic        mValid, mPend, mOverrun;
    int          mT;

    cga_text_fetch_if bus0 ();
    cga_text_fetch_if bus1 ();

    assign bus0.char_strobe = strobe;   assign bus1.char_strobe = strobe;
    assign bus0.crtc_addr = crtc;       assign bus1.crtc_addr = crtc;
    assign bus0.row_addr = row;         assign bus1.row_addr = row;
    assign bus0.display_enable = de;    assign bus1.display_enable = de;
    assign bus0.grph_mode = grph;       assign bus1.grph_mode = grph;
    assign bus0.pixel_data = pixData;   assign bus1.pixel_data = pixData;

    cga_text_fetch dut0 (.clk(clk), .reset(reset), .bus(bus0.master));
    cga_text_fetch #(.VRAM_BASE(19'h18000)) dut1 (.clk(clk), .reset(reset), .bus(bus1.master));

    always #5 clk = ~clk;

    // Registered arbiter: data for the address shown in one cycle appears in the next.
    always @(posedge clk) pixData <= vram[bus0.pixel_addr[13:0]];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic modelReset();
        mS0 = 8'h00; mS1 = 8'h00; mD0 = 8'h00; mD1 = 8'h00;
        mValid = 1'b0; mPend = 1'b0; mOverrun = 1'b0; mT = 0;
        addrQ.delete();
        cellQ.delete();
        cellDue = 1'b0;
    endtask

    // Drive one strobe, updating the reference model for the edge it lands on.
    task automatic applyStimulus(input logic [13:0] ca, input logic [4:0] ra,
                                 input logic de_i, input logic g);
        int          c;
        logic        busy;
        logic [13:0] a0;
        logic [13:0] a1;
        cell_t       e;
        c = cyc + 1;
        if (mPend && (mT + 2 < c)) mS0 = mD0;
        if (mPend && (mT + 3 < c)) begin
            mS1 = mD1;
            mValid = 1'b1;
            mPend = 1'b0;
        end
        busy = mPend;
        if (busy) mOverrun = 1'b1;
        e.c = mS0; e.a = mS1; e.v = mValid; e.ov = mOverrun;
        cellQ.push_back(e);
        mValid = 1'b0;
        if (!de_i) begin
            mS0 = 8'h00;
            mS1 = 8'h00;
        end
        if (!busy && de_i) begin
            a0 = g ? {ra[0], ca[11:0], 1'b0} : {ca[12:0], 1'b0};
            a1 = a0 + 14'd1;
            addrQ.push_back(a0);
            addrQ.push_back(a1);
            mD0 = vram[a0];
            mD1 = vram[a1];
            mT = c;
            mPend = 1'b1;
        end
        strobe = 1'b1; crtc = ca; row = ra; de = de_i; grph = g;
        tick();
        cellDue = 1'b1;
        strobe = 1'b0;
        crtc = 14'($urandom); row = 5'($urandom); de = 1'($urandom); grph = 1'($urandom);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_addr"}, bus0.pixel_addr, 0);
        checkOutput({tag, "_read"}, bus0.pixel_read, 0);
        checkOutput({tag, "_char"}, bus0.char_byte, 0);
        checkOutput({tag, "_attr"}, bus0.attr_byte, 0);
        checkOutput({tag, "_valid"}, bus0.cell_valid, 0);
        checkOutput({tag, "_ovr"}, bus0.fetch_overrun, 0);
        checkOutput({tag, "_addr_b"}, bus1.pixel_addr, 0);
    endtask

    // Scoreboard consumers: read beats and post-strobe cell outputs.
    always @(negedge clk) begin
        logic [13:0] ea;
        cell_t       e;
        if (!reset) begin
            if (bus0.pixel_read || bus1.pixel_read) begin
                if (addrQ.size() == 0) begin
                    checkOutput("unexpected_read", {bus1.pixel_read, bus0.pixel_read}, 0);
                end else begin
                    ea = addrQ.pop_front();
                    checkOutput("read0", bus0.pixel_read, 1);
                    checkOutput("read1", bus1.pixel_read, 1);
                    checkOutput("addr0", bus0.pixel_addr, {5'b0, ea});
                    checkOutput("addr1", bus1.pixel_addr, 19'h18000 | {5'b0, ea});
                end
            end
            if (cellDue) begin
                cellDue = 1'b0;
                if (cellQ.size() == 0) begin
                    checkOutput("cell_queue_empty", cellQ.size(), 1);
                end else begin
                    e = cellQ.pop_front();
                    checkOutput("char0", bus0.char_byte, e.c);
                    checkOutput("attr0", bus0.attr_byte, e.a);
                    checkOutput("valid0", bus0.cell_valid, e.v);
                    checkOutput("ovr0", bus0.fetch_overrun, e.ov);
                    checkOutput("char1", bus1.char_byte, e.c);
                    checkOutput("attr1", bus1.attr_byte, e.a);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16384; i++) vram[i] = 8'(i * 7 + (i >> 8) + 3);
        vram[14'h0100] = 8'h41; vram[14'h0101] = 8'h1F;
        vram[14'h200A] = 8'hA5; vram[14'h200B] = 8'h5A;
        vram[14'h3FFE] = 8'hC3; vram[14'h3FFF] = 8'h3C;
        vram[14'h0000] = 8'h77;
        vram[14'h0040] = 8'hFF; vram[14'h0041] = 8'hFF;

        reset = 1'b1; strobe = 1'b0; crtc = '0; row = '0; de = 1'b0; grph = 1'b0;
        modelReset();
        tick(); tick();
        checkAllZero("reset");
        reset = 1'b0;
        idle(2);

        applyStimulus(14'h0080, 5'd0, 1'b1, 1'b0);
        idle(7);
        applyStimulus(14'h2005, 5'd1, 1'b1, 1'b1);
        checkOutput("text_char_literal", bus0.char_byte, 8'h41);
        checkOutput("text_attr_literal", bus0.attr_byte, 8'h1F);
        checkOutput("text_valid_literal", bus0.cell_valid, 1);
        idle(5);
        applyStimulus(14'h1FFF, 5'd0, 1'b1, 1'b0);
        idle(4);
        applyStimulus(14'h2FFF, 5'b10001, 1'b1, 1'b1);
        idle(4);
        applyStimulus(14'h0020, 5'd0, 1'b1, 1'b0);
        idle(4);
        applyStimulus(14'h0100, 5'd0, 1'b0, 1'b0);
        checkOutput("snow_char_literal", bus0.char_byte, 8'hFF);
        idle(4);
        applyStimulus(14'h0100, 5'd0, 1'b0, 1'b0);
        checkOutput("blank_valid_literal", bus0.cell_valid, 0);
        idle(4);
        applyStimulus(14'h0000, 5'd0, 1'b1, 1'b1);
        idle(4);

        for (int k = 0; k < 12; k++) begin
            applyStimulus(14'($urandom), 5'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom));
            idle($urandom_range(3, 6));
        end

        applyStimulus(14'h0080, 5'd0, 1'b1, 1'b0);
        idle(1);
        applyStimulus(14'h0123, 5'd0, 1'b1, 1'b0);
        idle(6);
        applyStimulus(14'h0200, 5'd1, 1'b1, 1'b1);
        idle(6);
        applyStimulus(14'h0300, 5'd0, 1'b1, 1'b0);
        idle(6);

        applyStimulus(14'h0080, 5'd0, 1'b1, 1'b0);
        tick();
        reset = 1'b1;
        #1;
        modelReset();
        checkAllZero("midreset");
        tick(); tick();
        checkAllZero("heldreset");
        reset = 1'b0;
        idle(2);
        applyStimulus(14'h1FFF, 5'd0, 1'b1, 1'b0);
        idle(5);
        applyStimulus(14'h0080, 5'd0, 1'b1, 1'b0);
        idle(5);
        applyStimulus(14'h0000, 5'd0, 1'b0, 1'b0);
        idle(6);

        checkOutput("reads_outstanding", addrQ.size(), 0);
        checkOutput("cells_outstanding", cellQ.size(), 0);
        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
